// File: rtl/pcie_axi2sram_rd_pkg.sv
`default_nettype none
// ============================================================================
// pcie_axi2sram_rd_pkg : shared AXI encodings and FSM states for the reader
// Revision: 1.0
// ============================================================================
package pcie_axi2sram_rd_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam int BEAT_BYTES = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pcie_axi2sram_rd_fifo.sv
`default_nettype none
// ============================================================================
// axi_rd_fifo : synchronous FIFO with occupancy count for read beats
// Revision: 1.0
// ============================================================================
module axi_rd_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != (PW+1)'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/pcie_axi2sram_rd.sv
`default_nettype none
// ============================================================================
// pcie_axi2sram_rd : AXI4 read slave streaming bursts from a sync-read SRAM
// Revision: 1.0
// ============================================================================
module pcie_axi2sram_rd
  import pcie_axi2sram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  axi_arvalid,
  input  logic [63:0]           axi_araddr,
  input  logic [11:0]           axi_arlen,
  input  logic [2:0]            axi_arsize,
  input  logic [1:0]            axi_arburst,
  output logic                  axi_arready,
  output logic                  axi_rvalid,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  input  logic                  axi_rready,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int OFS = $clog2(BEAT_BYTES);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [12:0]           beats;
  logic [12:0]           issue_cnt;
  logic [1:0]            burst;
  logic                  inflight;
  logic                  inflight_last;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  ar_hs;
  logic                  pop;
  logic                  issue;
  logic                  unused_ok;

  assign unused_ok   = ^{axi_arsize, axi_araddr[63:ADDR_WIDTH+OFS], axi_araddr[OFS-1:0]};

  assign axi_arready = (state == ST_IDLE) && rst_n;
  assign ar_hs       = axi_arvalid && axi_arready;
  assign axi_rvalid  = !fifo_empty;
  assign pop         = axi_rvalid && axi_rready;
  assign axi_rdata   = axi_rvalid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign axi_rlast   = axi_rvalid && fifo_head[DATA_WIDTH];
  assign axi_rresp   = RESP_OKAY;

  // Credit: buffered plus in-flight entries, less a pop in this same cycle
  assign issue = (state == ST_BURST) && (issue_cnt < beats) &&
                 (({1'b0, fifo_count} + (CW+1)'(inflight)) <
                  ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop)));

  assign sram_ren   = issue;
  assign sram_raddr = addr;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (ar_hs) state_nx = ST_BURST;
      ST_BURST: if (pop && axi_rlast) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      beats         <= '0;
      issue_cnt     <= '0;
      burst         <= BURST_INCR;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= issue;
      inflight_last <= issue && (issue_cnt == beats - 13'd1);
      if (ar_hs) begin
        addr      <= axi_araddr[ADDR_WIDTH+OFS-1:OFS];
        beats     <= {1'b0, axi_arlen} + 13'd1;
        issue_cnt <= '0;
        burst     <= axi_arburst;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 13'd1;
        if (burst != BURST_FIXED) addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

  axi_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata ({inflight_last, sram_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pcie_axi2sram_rd.sv
`default_nettype none
// ============================================================================
// tb_pcie_axi2sram_rd : randomized self-checking bench with SRAM and burst model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pcie_axi2sram_rd;

  localparam int DW    = 256;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          axi_arvalid = 1'b0;
  logic [63:0]   axi_araddr = '0;
  logic [11:0]   axi_arlen = '0;
  logic [2:0]    axi_arsize = 3'd5;
  logic [1:0]    axi_arburst = 2'b01;
  logic          axi_arready;
  logic          axi_rvalid;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rready = 1'b0;
  logic          sram_ren;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcie_axi2sram_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
  );

  // SRAM with one-cycle synchronous read
  logic [DW-1:0] mem [WORDS];
  always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            ren_addr_q[$];
  int            ren_cyc_q[$];
  int            beat_cyc_q[$];
  logic [DW-1:0] beat_data_q[$];
  bit            beat_last_q[$];
  int            resp_err = 0, stall_err = 0, outstanding = 0, max_out = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      if (sram_ren) begin
        ren_addr_q.push_back(int'(sram_raddr));
        ren_cyc_q.push_back(cyc);
      end
      if (prev_stall && (!axi_rvalid || axi_rdata !== prev_data || axi_rlast !== prev_last))
        stall_err++;
      if (axi_rvalid && axi_rready) begin
        beat_data_q.push_back(axi_rdata);
        beat_last_q.push_back(axi_rlast);
        beat_cyc_q.push_back(cyc);
        if (axi_rresp !== 2'b00) resp_err++;
      end
      outstanding += int'(sram_ren) - int'(axi_rvalid && axi_rready);
      if (outstanding > max_out) max_out = outstanding;
      prev_stall = axi_rvalid && !axi_rready;
      prev_data  = axi_rdata;
      prev_last  = axi_rlast;
    end
  end

  task automatic clear_mon();
    ren_addr_q.delete(); ren_cyc_q.delete();
    beat_cyc_q.delete(); beat_data_q.delete(); beat_last_q.delete();
    resp_err = 0; stall_err = 0; max_out = 0;
  endtask

  task automatic do_ar(input int word, input int len, input logic [1:0] bt, input bit keep,
                       output int hs_cyc);
    @(posedge clk); #1;
    axi_arvalid = 1'b1;
    axi_araddr  = {49'($urandom), 10'(word), 5'($urandom)};
    axi_arlen   = 12'(len);
    axi_arburst = bt;
    axi_arsize  = 3'd5;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (axi_arready) break;
    end
    checks++;
    if (axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL ar_accept: arready=%b required 1", axi_arready);
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
    if (!keep) axi_arvalid = 1'b0;
  endtask

  // mode 0: rready=1, mode 1: pattern 1,0,0,1, mode 2: random
  task automatic collect(input int n, input int mode);
    int k = 0;
    for (int t = 0; t < 400 + 8 * n; t++) begin
      if (beat_data_q.size() >= n) break;
      @(posedge clk); #1;
      case (mode)
        0:       axi_rready = 1'b1;
        1:       axi_rready = ((k % 4) == 0) || ((k % 4) == 3);
        default: axi_rready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
    checks++;
    if (beat_data_q.size() != n) begin
      errors++;
      $display("FAIL beat_count: got %0d beats required %0d", beat_data_q.size(), n);
    end
  endtask

  // Reference: address sequence from start/burst rules, data from the SRAM image
  task automatic check_burst(input int start, input int len, input logic [1:0] bt,
                             input int hs_cyc, input bit timing);
    int n = len + 1;
    int ea;
    checks++;
    if (ren_addr_q.size() != n) begin
      errors++;
      $display("FAIL ren_count: got %0d reads required %0d", ren_addr_q.size(), n);
    end
    checks++;
    if (ren_cyc_q.size() == 0 || ren_cyc_q[0] != hs_cyc + 1) begin
      errors++;
      $display("FAIL first_ren_cycle: got %0d required %0d",
               (ren_cyc_q.size() > 0) ? ren_cyc_q[0] : -1, hs_cyc + 1);
    end
    for (int i = 0; i < n; i++) begin
      ea = (bt == 2'b00) ? start : ((start + i) % WORDS);
      if (i < ren_addr_q.size()) begin
        checks++;
        if (ren_addr_q[i] != ea) begin
          errors++;
          $display("FAIL raddr[%0d]: got %0d required %0d", i, ren_addr_q[i], ea);
        end
      end
      if (i < beat_data_q.size()) begin
        checks++;
        if (beat_data_q[i] !== mem[ea] || beat_last_q[i] !== (i == n - 1)) begin
          errors++;
          $display("FAIL beat[%0d]: data=%h last=%b required data=%h last=%b",
                   i, beat_data_q[i], beat_last_q[i], mem[ea], (i == n - 1));
        end
        if (timing) begin
          checks++;
          if (beat_cyc_q[i] != hs_cyc + 3 + i || (i < ren_cyc_q.size() && ren_cyc_q[i] != hs_cyc + 1 + i)) begin
            errors++;
            $display("FAIL stream_timing[%0d]: beat cycle %0d required %0d",
                     i, beat_cyc_q[i], hs_cyc + 3 + i);
          end
        end
      end
    end
    checks++;
    if (resp_err != 0 || stall_err != 0 || max_out > DEPTH) begin
      errors++;
      $display("FAIL r_channel: resp_err=%0d stall_err=%0d max_entries=%0d required 0/0/<=%0d",
               resp_err, stall_err, max_out, DEPTH);
    end
  endtask

  task automatic run_burst(input int word, input int len, input logic [1:0] bt, input int mode);
    int hs;
    clear_mon();
    do_ar(word, len, bt, 1'b0, hs);
    collect(len + 1, mode);
    checks++;
    if (axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL arready_after_last: got %b required 1", axi_arready);
    end
    check_burst(word, len, bt, hs, mode == 0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (axi_arready !== 1'b0 || axi_rvalid !== 1'b0 || axi_rlast !== 1'b0 || axi_rdata !== '0 ||
        axi_rresp !== 2'b00 || sram_ren !== 1'b0 || sram_raddr !== '0) begin
      errors++;
      $display("FAIL reset_state: arready=%b rvalid=%b rlast=%b rresp=%b ren=%b raddr=%0d required all 0",
               axi_arready, axi_rvalid, axi_rlast, axi_rresp, sram_ren, sram_raddr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL idle_arready: got %b required 1", axi_arready);
    end
  endtask

  task automatic test_single();
    run_burst(0, 0, 2'b01, 0);
  endtask

  task automatic test_incr4();
    run_burst(2, 3, 2'b01, 0);
  endtask

  task automatic test_backpressure();
    run_burst(2, 3, 2'b01, 1);
    run_burst(100, 11, 2'b01, 1);
  endtask

  task automatic test_wrap_fixed();
    run_burst(1023, 1, 2'b01, 0);
    run_burst(1, 2, 2'b00, 0);
  endtask

  task automatic test_back_to_back();
    int hs, hs2, viol = 0, word;
    word = int'($urandom_range(0, WORDS - 1));
    clear_mon();
    do_ar(word, 2, 2'b01, 1'b1, hs);
    axi_rready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (beat_data_q.size() >= 3) break;
      if (axi_arready !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    checks++;
    if (viol != 0 || beat_data_q.size() != 3) begin
      errors++;
      $display("FAIL ar_blocked: arready high %0d times, beats=%0d required 0 and 3",
               viol, beat_data_q.size());
    end
    checks++;
    if (axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL rearm: arready=%b required 1", axi_arready);
    end
    check_burst(word, 2, 2'b01, hs, 1'b1);
    clear_mon();
    @(negedge clk);
    hs2 = cyc;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    collect(3, 0);
    check_burst(word, 2, 2'b01, hs2, 1'b1);
  endtask

  task automatic test_reset_mid();
    int hs;
    clear_mon();
    do_ar(50, 7, 2'b01, 1'b0, hs);
    axi_rready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (beat_data_q.size() >= 2) break;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (axi_rvalid !== 1'b0 || sram_ren !== 1'b0 || axi_arready !== 1'b0 || axi_rlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rvalid=%b ren=%b arready=%b rlast=%b required 0",
               axi_rvalid, sram_ren, axi_arready, axi_rlast);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (beat_data_q.size() != 0 || ren_addr_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: beats=%0d reads=%0d required 0/0",
               beat_data_q.size(), ren_addr_q.size());
    end
    run_burst(777, 0, 2'b01, 0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++)
      run_burst(int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, 20)),
                2'($urandom_range(0, 3)), 2);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    test_reset();
    test_single();
    test_incr4();
    test_backpressure();
    test_wrap_fixed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
